shift_fifo: RTL and testbench
=============================

Name: shift_fifo

Overview:
- Parametrised successor to the single-bit push-clocked shift chain and its pointer-indexed output stage.
- A WIDTH-bit, DEPTH-entry FIFO built as a shift register with an occupancy counter and a registered read port.
- Runs on one system clock. Push and pop are synchronous enables, not clocks.
- Sits between a serial/byte producer and a consumer that drains on demand.

Parameters:
- WIDTH, 8, bits per entry.
- DEPTH, 8, number of entries, ≥2.
- CW, $clog2(DEPTH+1), count width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- push  input  1  write request; D_in is captured when accepted.
- pop  input  1  read request; oldest entry goes to D_out when accepted.
- clr  input  1  synchronous flush: empties the FIFO, keeps storage contents.
- D_in  input  WIDTH  write data.
- D_out  output  WIDTH  registered read data.
- valid  output  1  one-cycle pulse: D_out updated this cycle.
- count  output  CW  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  one-cycle pulse: push rejected.
- underflow  output  1  one-cycle pulse: pop rejected.

Behaviour:
- Reset (rst low, asynchronous): all storage stages=0, count=0, D_out=0, valid=0, overflow=0, underflow=0. Therefore empty=1 and full=0.
- Storage layout: stages mem[0..DEPTH-1]. An accepted push does mem[0]<=D_in and mem[i]<=mem[i-1] for all i. The oldest valid entry is always mem[count-1].
- full and empty are combinational decodes of count. They are never registered separately.
- Accept rules, evaluated on pre-edge count:
  - push_ok = push & (!full | pop).
  - pop_ok = pop & !empty.
- Count update:
  - push_ok & !pop_ok: +1.
  - pop_ok & !push_ok: −1.
  - Both: unchanged.
  - Neither: unchanged.
- Read: on pop_ok, D_out<=mem[count-1] (pre-shift value) and valid<=1. Latency is one cycle from the pop edge.
- D_out holds its value when there is no pop_ok. valid is 0 in any cycle without pop_ok.
- Simultaneous push & pop:
  - Non-empty: the oldest entry is read and the new entry is shifted in; count unchanged.
  - When full this is allowed and overflow=0.
  - When empty: the push is accepted and the pop is rejected. Result: count=1, underflow=1, valid=0.
- Push when full without pop: no shift, count stays DEPTH, overflow=1 for one cycle.
- Pop when empty: D_out holds, underflow=1 for one cycle, count stays 0.
- clr has priority over push and pop. Next cycle: count=0, valid=0, overflow=0, underflow=0. D_out and mem are not modified.
- Reset asserted mid-operation clears state immediately, regardless of clk. The first accepted push after rst deasserts lands in mem[0] with count=1.
- count never exceeds DEPTH and never wraps below 0. The bench asserts this invariant every cycle.

Test Plan:
- Reset, then idle 3 cycles -> count=0, empty=1, full=0, D_out=0, valid never 1.
- Push 0x11,0x22,0x33, then pop ×3 -> D_out=0x11,0x22,0x33 on successive cycles, valid=1 each, count 3→0, empty=1 at end.
- Push 8 values 0xA0..0xA7 (DEPTH=8), then a 9th push 0xFF -> full=1, overflow pulses once, count=8. Draining returns 0xA0..0xA7, never 0xFF.
- Full FIFO (0xA0..0xA7), push 0xB0 with pop in the same cycle -> D_out=0xA0, count stays 8, overflow=0. Draining the rest yields 0xA1..0xA7, 0xB0.
- Empty FIFO, push 0x5A with pop in the same cycle -> underflow=1, valid=0, count=1. Next pop gives D_out=0x5A. A further pop gives underflow=1 and D_out still 0x5A.
- Load 5 entries, assert clr with push -> count=0 next cycle and the push is ignored. Then load 4 entries and pull rst low between clock edges -> count=0 and D_out=0 immediately, before the next edge.

Source files
------------

// File: rtl/shift_fifo.sv
// Shift-register FIFO: new entries enter at mem[0] and the oldest entry sits at mem[count-1].
// The read port is registered, and the full/empty flags are decoded from the occupancy count.
module shift_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] D_in,
  output logic [WIDTH-1:0] D_out,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] d_out_q, rd_data;
  logic             valid_q, overflow_q, underflow_q;
  logic             push_ok, pop_ok;
  logic [CW-1:0]    rd_idx;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO still accepts a push when a pop frees the oldest slot in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign rd_idx  = count_q - CW'(1);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (rd_idx == CW'(i)) rd_data = mem_q[i];
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (!clr && push_ok) begin
      mem_q[0] <= D_in;
      for (int i = 1; i < int'(DEPTH); i++) mem_q[i] <= mem_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      d_out_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      valid_q     <= ~clr & pop_ok;
      overflow_q  <= ~clr & push & ~push_ok;
      underflow_q <= ~clr & pop & ~pop_ok;
      if (!clr && pop_ok) d_out_q <= rd_data;
    end
  end

  assign D_out     = d_out_q;
  assign valid     = valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_shift_fifo.sv
// Bench for shift_fifo: runs directed scenarios and then random traffic.
// Every cycle the outputs are compared against a queue-based reference model.
module tb_shift_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             push, pop, clr;
  logic [WIDTH-1:0] D_in;
  logic [WIDTH-1:0] D_out;
  logic             valid, full, empty, overflow, underflow;
  logic [CW-1:0]    count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  bit               m_valid, m_ov, m_un;

  shift_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clr       (clr),
    .D_in      (D_in),
    .D_out     (D_out),
    .valid     (valid),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(q.size()));
    check("d_out", 32'(D_out), 32'(m_dout));
    check("valid", 32'(valid), 32'(m_valid));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("count_bound", 32'(int'(count) <= DEPTH), 32'd1);
  endtask

  // The model is updated from the pre-edge state, then the DUT is sampled 1ns after the edge.
  task automatic step(input bit p, input bit o, input bit c, input logic [WIDTH-1:0] d);
    bit was_full, was_empty;
    push = p; pop = o; clr = c; D_in = d;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (c) begin
      q.delete();
      m_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      m_valid = o && !was_empty;
      m_un    = o && was_empty;
      m_ov    = p && was_full && !o;
      if (m_valid) m_dout = q.pop_front();
      if (p && !m_ov) q.push_back(d);
    end
    @(posedge clk);
    #1;
    compare_all();
    push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  initial begin
    int ov_pulses;
    rst = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; D_in = '0;
    model_reset();
    #12 rst = 1'b1;
    compare_all();

    // Idle after reset
    repeat (3) step(0, 0, 0, 8'h00);

    // Basic ordering
    step(1, 0, 0, 8'h11); step(1, 0, 0, 8'h22); step(1, 0, 0, 8'h33);
    step(0, 1, 0, 8'h00); check("first_pop", 32'(D_out), 32'h11);
    step(0, 1, 0, 8'h00); step(0, 1, 0, 8'h00);
    check("third_pop", 32'(D_out), 32'h33);

    // Fill, then overflow
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'hA0 + 8'(i));
    ov_pulses = 0;
    step(1, 0, 0, 8'hFF);
    if (overflow) ov_pulses++;
    step(0, 0, 0, 8'h00);
    if (overflow) ov_pulses++;
    check("ov_once", 32'(ov_pulses), 32'd1);
    check("full_count", 32'(count), 32'(DEPTH));

    // Push and pop together while full, then drain
    step(1, 1, 0, 8'hB0);
    check("full_pp_dout", 32'(D_out), 32'hA0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00);
    check("drain_last", 32'(D_out), 32'hB0);

    // Push and pop together while empty, then pop from an empty FIFO
    step(1, 1, 0, 8'h5A);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    check("hold_dout", 32'(D_out), 32'h5A);

    // A clear takes priority over a simultaneous push
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h30 + i));
    step(1, 0, 1, 8'hEE);

    // Asynchronous reset asserted between clock edges
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h40 + i));
    step(0, 1, 0, 8'h00);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_count", 32'(count), 32'd0);
    check("async_dout", 32'(D_out), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    #3 rst = 1'b1;
    step(1, 0, 0, 8'h77);
    step(0, 1, 0, 8'h00);
    check("post_rst_pop", 32'(D_out), 32'h77);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 3), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
